// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage controller and the data memory.
// The controller drives the request side; memory answers with a one-cycle ack.
interface mem_access_unit_if #(
    parameter int PC_BITS = 32
);
    logic               req;
    logic               we;
    logic [PC_BITS-1:0] addr;
    logic [PC_BITS-1:0] wdata;
    logic [PC_BITS-1:0] rdata;
    logic               ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns M-stage load/store controls into one req/ack
// bus transaction, stalling the pipeline until the result is ready for MEM/WB.
module mem_access_unit #(
    parameter int PC_BITS = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               mem_write_m,
    input  logic               mem_to_reg_m,
    input  logic [PC_BITS-1:0] alu_out_m,
    input  logic [PC_BITS-1:0] write_data_m,
    output logic               stall_m,
    output logic [PC_BITS-1:0] read_data_m,
    output logic               misalign_m,
    output logic               bus_err_m,
    mem_access_unit_if.master  dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state;
    logic [CW-1:0] count;
    logic          op;
    logic          aligned;

    assign op      = mem_write_m | mem_to_reg_m;
    assign aligned = (alu_out_m[1:0] == 2'b00);

    // Misaligned accesses never touch the bus; the instruction simply proceeds
    always_comb begin
        stall_m    = 1'b0;
        misalign_m = 1'b0;
        unique case (state)
            IDLE: begin
                stall_m    = op & aligned;
                misalign_m = op & ~aligned;
            end
            BUSY:    stall_m = 1'b1;
            DONE:    stall_m = 1'b0;
            default: stall_m = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            dmem.req    <= 1'b0;
            dmem.we     <= 1'b0;
            dmem.addr   <= '0;
            dmem.wdata  <= '0;
            read_data_m <= '0;
            bus_err_m   <= 1'b0;
            count       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op && aligned) begin
                        dmem.req   <= 1'b1;
                        dmem.we    <= mem_write_m;
                        dmem.addr  <= alu_out_m;
                        dmem.wdata <= write_data_m;
                        count      <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack on the final allowed cycle still wins over the timeout
                    if (dmem.ack) begin
                        dmem.req    <= 1'b0;
                        read_data_m <= dmem.we ? '0 : dmem.rdata;
                        bus_err_m   <= 1'b0;
                        state       <= DONE;
                    end else if (TIMEOUT != 0 && count == LAST) begin
                        dmem.req    <= 1'b0;
                        read_data_m <= '0;
                        bus_err_m   <= 1'b1;
                        state       <= DONE;
                    end else if (count != '1) begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    bus_err_m <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of M-stage accesses checked through a
// scoreboard at completion, plus hand-written back-to-back and reset sequences.
module tb_mem_access_unit;

    localparam int PCB = 32;
    localparam int TO  = 4;

    logic           clk = 1'b0;
    logic           clr = 1'b0;
    logic           mem_write_m = 1'b0;
    logic           mem_to_reg_m = 1'b0;
    logic [PCB-1:0] alu_out_m = '0;
    logic [PCB-1:0] write_data_m = '0;
    logic           stall_m;
    logic [PCB-1:0] read_data_m;
    logic           misalign_m;
    logic           bus_err_m;

    mem_access_unit_if #(.PC_BITS(PCB)) bus ();

    mem_access_unit #(.PC_BITS(PCB), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .clr          (clr),
        .mem_write_m  (mem_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .stall_m      (stall_m),
        .read_data_m  (read_data_m),
        .misalign_m   (misalign_m),
        .bus_err_m    (bus_err_m),
        .dmem         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_delay;
        logic        exp_mis;
        logic        exp_we;
        logic [31:0] exp_read;
        logic        exp_err;
        int          exp_req;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          req_cycles;
        int          stall_cycles;
    } exp_t;

    exp_t        sbq[$];
    vec_t        vecs[7];
    int          total = 0;
    int          bad = 0;
    int          req_issued = 0;
    int          req_cycles, stall_cycles;
    bit          prev_stall, prev_req;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: got completion expected none");
            return;
        end
        e = sbq.pop_front();
        check("addr", cap_addr, e.addr);
        check("we", 32'(cap_we), 32'(e.we));
        check("wdata", cap_wdata, e.wdata);
        check("read_data", read_data_m, e.rdata);
        check("bus_err", 32'(bus_err_m), 32'(e.err));
        check("req_cycles", 32'(req_cycles), 32'(e.req_cycles));
        check("stall_cycles", 32'(stall_cycles), 32'(e.stall_cycles));
    endtask

    // Called once per cycle just after the falling edge, with inputs settled
    task automatic sample_cycle(output bit done);
        done = 1'b0;
        if (stall_m) stall_cycles++;
        if (bus.req) begin
            req_cycles++;
            if (!prev_req) begin
                req_issued++;
                cap_addr  = bus.addr;
                cap_we    = bus.we;
                cap_wdata = bus.wdata;
            end
        end
        if (prev_stall && !stall_m) begin
            done = 1'b1;
            check_output();
        end
        prev_stall = stall_m;
        prev_req   = bus.req;
    endtask

    task automatic apply_stimulus(input vec_t v);
        bit done;
        int busy;
        @(negedge clk);
        mem_write_m  = v.wr;
        mem_to_reg_m = v.rd;
        alu_out_m    = v.addr;
        write_data_m = v.wdata;
        bus.ack      = 1'b0;
        #1;
        stall_cycles = 0;
        req_cycles   = 0;
        prev_stall   = 1'b0;
        prev_req     = 1'b0;
        if (v.exp_mis) begin
            check("misalign", 32'(misalign_m), 32'd1);
            check("misalign_stall", 32'(stall_m), 32'd0);
            @(negedge clk);
            mem_write_m  = 1'b0;
            mem_to_reg_m = 1'b0;
            #1;
            check("misalign_no_req", 32'(bus.req), 32'd0);
            return;
        end
        check("aligned_no_misalign", 32'(misalign_m), 32'd0);
        sbq.push_back('{v.addr, v.exp_we, v.wdata, v.exp_read, v.exp_err, v.exp_req, v.exp_stall});
        busy = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            sample_cycle(done);
            if (!done) begin
                if (bus.req) begin
                    bus.ack   = (v.ack_delay >= 0 && busy == v.ack_delay);
                    bus.rdata = bus.ack ? v.rdata : $urandom;
                    busy++;
                end
                @(negedge clk);
                bus.ack = 1'b0;
                #1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL completion_timeout: got no DONE expected DONE within 40 cycles");
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mem_write_m  = 1'b0;
        mem_to_reg_m = 1'b0;
        bus.ack      = 1'b0;
        #1;
        check("idle_bus_err", 32'(bus_err_m), 32'd0);
        check("idle_stall", 32'(stall_m), 32'd0);
        check("idle_req", 32'(bus.req), 32'd0);
    endtask

    initial begin
        int base;
        vec_t v;
        bus.ack   = 1'b0;
        bus.rdata = '0;

        //        wr rd addr          wdata         rdata         dly mis we read          err req stall
        vecs[0] = '{0, 1, 32'h100, 32'h0,        32'hDEADBEEF, 0,  0,  0, 32'hDEADBEEF, 0,  1,  2};
        vecs[1] = '{1, 0, 32'h204, 32'h12345678, 32'hCAFEF00D, 3,  0,  1, 32'h0,        0,  4,  5};
        vecs[2] = '{0, 1, 32'h102, 32'h0,        32'h0,        0,  1,  0, 32'h0,        0,  0,  0};
        vecs[3] = '{0, 1, 32'h300, 32'h0,        32'h0,        -1, 0,  0, 32'h0,        1,  4,  5};
        vecs[4] = '{1, 1, 32'h40,  32'h0000A5A5, 32'h77777777, 1,  0,  1, 32'h0,        0,  2,  3};
        vecs[5] = '{1, 0, 32'h203, 32'h11111111, 32'h0,        0,  1,  1, 32'h0,        0,  0,  0};
        vecs[6] = '{0, 1, 32'h8,   32'h0,        32'h0BADF00D, 2,  0,  0, 32'h0BADF00D, 0,  3,  4};

        #1 clr = 1'b1;
        #20;
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_read", read_data_m, 32'd0);
        check("rst_err", 32'(bus_err_m), 32'd0);
        check("rst_stall", 32'(stall_m), 32'd0);
        check("rst_misalign", 32'(misalign_m), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
            idle_cycle();
        end

        // Ack and read data while idle must not disturb anything
        @(negedge clk);
        bus.ack   = 1'b1;
        bus.rdata = 32'hFFFF0000;
        @(negedge clk);
        bus.ack = 1'b0;
        #1;
        check("idle_ack_req", 32'(bus.req), 32'd0);
        check("idle_ack_read", read_data_m, 32'h0BADF00D);

        // Back-to-back loads with no idle gap between them
        base = req_issued;
        v = '{0, 1, 32'h10, 32'h0, 32'h01010101, 0, 0, 0, 32'h01010101, 0, 1, 2};
        apply_stimulus(v);
        v = '{0, 1, 32'h14, 32'h0, 32'h02020202, 0, 0, 0, 32'h02020202, 0, 1, 2};
        apply_stimulus(v);
        idle_cycle();
        check("b2b_req_count", 32'(req_issued - base), 32'd2);

        // Reset pulsed while the bus request is outstanding
        @(negedge clk);
        mem_to_reg_m = 1'b1;
        alu_out_m    = 32'h500;
        @(negedge clk);
        #1;
        check("clr_pre_req", 32'(bus.req), 32'd1);
        #2;
        clr          = 1'b1;
        mem_to_reg_m = 1'b0;
        #1;
        check("clr_req_drop", 32'(bus.req), 32'd0);
        check("clr_stall_drop", 32'(stall_m), 32'd0);
        check("clr_no_err", 32'(bus_err_m), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        v = '{0, 1, 32'h600, 32'h0, 32'h600DCAFE, 0, 0, 0, 32'h600DCAFE, 0, 1, 2};
        apply_stimulus(v);
        idle_cycle();

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover: got %0d expected 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage controller sitting directly downstream of the EX/MEM pipeline register. It consumes the M-stage control and data signals and performs the load or store on an external data-memory bus using a req/ack handshake. It drives stall_m back to the EX/MEM register and upstream stages while an access is outstanding. It presents the load result, plus alignment and bus-error flags, to the MEM/WB register.

Parameters:
PC_BITS, 32, datapath and address width.
TIMEOUT, 16, maximum cycles spent in BUSY before aborting; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
clr  in  1  asynchronous active-high reset.
mem_write_m  in  1  store request from EX/MEM.
mem_to_reg_m  in  1  load request from EX/MEM.
alu_out_m  in  PC_BITS  byte address.
write_data_m  in  PC_BITS  store data.
stall_m  out  1  hold EX/MEM and upstream stages.
dmem_req  out  1  bus request, registered.
dmem_we  out  1  1 = write, registered.
dmem_addr  out  PC_BITS  word-aligned address, registered.
dmem_wdata  out  PC_BITS  store data, registered.
dmem_rdata  in  PC_BITS  read data, sampled when dmem_ack=1.
dmem_ack  in  1  bus completion, 1-cycle pulse.
read_data_m  out  PC_BITS  load result, registered.
misalign_m  out  1  misaligned access flag, combinational.
bus_err_m  out  1  timeout flag, registered.

Behaviour:
- Reset (clr=1, async): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, read_data_m=0, bus_err_m=0, timeout counter=0. stall_m=0 and misalign_m=0 follow from IDLE with no operation present.
- op = mem_write_m | mem_to_reg_m. If both are set, the access is treated as a store.
- IDLE:
  - op=1 and alu_out_m[1:0]!=0: misalign_m=1, stall_m=0, no bus access; the instruction proceeds.
  - op=1 and aligned: stall_m=1. Next edge: dmem_req<=1, dmem_we<=mem_write_m, dmem_addr<=alu_out_m, dmem_wdata<=write_data_m, counter<=0, state<=BUSY.
  - op=0: stall_m=0; all bus outputs hold.
- BUSY: stall_m=1 and dmem_req held at 1.
  - dmem_ack=1: dmem_req<=0; on a load, read_data_m<=dmem_rdata; on a store, read_data_m<=0. bus_err_m<=0, state<=DONE.
  - dmem_ack=0 with TIMEOUT!=0 and counter==TIMEOUT-1: dmem_req<=0, read_data_m<=0, bus_err_m<=1, state<=DONE.
  - Otherwise: counter increments.
- DONE: stall_m=0 for exactly one cycle, so EX/MEM advances on this edge. read_data_m and bus_err_m are valid for MEM/WB in this cycle. Next edge: bus_err_m<=0, state<=IDLE.
- Latency: a load or store with ack in its first BUSY cycle takes 3 cycles (IDLE, BUSY, DONE), i.e. 2 stall cycles.
- Back-to-back accesses: after DONE, the next instruction is evaluated in IDLE. No request is ever reissued for the same instruction.
- dmem_ack seen while in IDLE or DONE is ignored.
- dmem_rdata is sampled only in BUSY when dmem_ack=1.
- The counter is PC_BITS-independent and at least clog2(TIMEOUT+1) bits wide; it does not wrap.
- clr asserted mid-BUSY aborts immediately: dmem_req=0 and no flags are raised.

Test Plan:
- Aligned load: alu_out_m=0x100, mem_to_reg_m=1, ack with rdata=0xDEADBEEF in the first BUSY cycle -> stall_m=1 for 2 cycles, dmem_addr=0x100, dmem_we=0, read_data_m=0xDEADBEEF in DONE, bus_err_m=0.
- Store with ack delayed 3 cycles: address 0x204, data 0x12345678 -> dmem_req high for 4 cycles, dmem_we=1, dmem_wdata=0x12345678, stall_m high for 5 cycles, read_data_m=0.
- Misaligned load at 0x102 -> misalign_m=1 the same cycle, stall_m=0, dmem_req never asserts.
- TIMEOUT=4 with no ack -> dmem_req high for 4 cycles, then bus_err_m=1 and read_data_m=0 for one cycle in DONE, then IDLE.
- Back-to-back loads at 0x10 and 0x14, each acked immediately -> exactly two requests issued with those addresses, each load sees 2 stall cycles, no duplicate request.
- clr pulsed during BUSY -> dmem_req and stall_m drop asynchronously; next access starts cleanly from IDLE.
